// File: rtl/fb_bank_arbiter_if.sv
// Bus bundle for fb_bank_arbiter: reader, host writer, swap control and frame-buffer RAM.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface fb_bank_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              swap_req;
  logic              frame_end;
  logic              swap_done;
  logic              disp_bank;
  logic              swap_pend;
  logic              busy;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_end, mem_rdata,
    output rd_gnt, rd_valid, rd_data, wr_ack, swap_done, disp_bank, swap_pend, busy,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_end, mem_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_ack, swap_done, disp_bank, swap_pend, busy,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_bank_arbiter.sv
// Double-buffered frame-buffer arbiter: reader on the display bank, host writes to the back bank,
// tear-free swap at frame_end. Define FB_CLEAR_EN for a zero-fill sweep of the RAM after reset.
module fb_bank_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 12,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  fb_bank_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SWAP = 2'd2
  } swap_state_e;

  swap_state_e       state_r;
  swap_state_e       state_s;
  logic              disp_bank_r;
  logic              rd_valid_r;
  logic [CNT_W-1:0]  starve_r;
  logic [ADDR_W:0]   addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              busy_s;
  logic [ADDR_W:0]   clr_addr_s;
  logic              active_s;
  logic              starve_full_s;
  logic              wr_win_s;
  logic              rd_gnt_s;
  logic [ADDR_W:0]   mem_addr_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_wdata_s;

`ifdef FB_CLEAR_EN
  logic            clr_active_r;
  logic [ADDR_W:0] clr_addr_r;

  // Zero-fill sweep over both banks, one address per cycle, starting on reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_active_r <= 1'b1;
      clr_addr_r   <= '0;
    end else if (clr_active_r) begin
      clr_addr_r <= clr_addr_r + {{ADDR_W{1'b0}}, 1'b1};
      if (&clr_addr_r) begin
        clr_active_r <= 1'b0;
      end
    end
  end

  assign busy_s     = clr_active_r;
  assign clr_addr_s = clr_addr_r;
`else
  assign busy_s     = 1'b0;
  assign clr_addr_s = '0;
`endif

  // Grants are combinational, so they are also gated by reset to keep the RAM quiet while held.
  assign active_s = rst & ~busy_s;

  // One RAM access per cycle: reader by default, writer when the reader is idle or starved.
  always_comb begin
    starve_full_s = (starve_r == CNT_W'(STARVE_MAX));
    wr_win_s      = active_s && bus.wr_req && (!bus.rd_req || starve_full_s);
    rd_gnt_s      = active_s && bus.rd_req && !wr_win_s;
    mem_addr_s    = addr_r;
    mem_we_s      = 1'b0;
    mem_wdata_s   = wdata_r;
    if (busy_s) begin
      mem_addr_s  = clr_addr_s;
      mem_we_s    = 1'b1;
      mem_wdata_s = '0;
    end else if (wr_win_s) begin
      mem_addr_s  = {~disp_bank_r, bus.wr_addr};
      mem_we_s    = 1'b1;
      mem_wdata_s = bus.wr_data;
    end else if (rd_gnt_s) begin
      mem_addr_s  = {disp_bank_r, bus.rd_addr};
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Datapath state: held RAM address/data, read-valid pipeline and writer starvation count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r     <= '0;
      wdata_r    <= '0;
      rd_valid_r <= 1'b0;
      starve_r   <= '0;
    end else begin
      addr_r     <= mem_addr_s;
      wdata_r    <= mem_wdata_s;
      rd_valid_r <= rd_gnt_s;
      if (!bus.wr_req || wr_win_s || busy_s) begin
        starve_r <= '0;
      end else if (!starve_full_s) begin
        starve_r <= starve_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Swap next-state: a request waits for the panel's frame boundary; extra requests are dropped.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.swap_req && !busy_s) begin
          state_s = PEND;
        end else begin
          state_s = IDLE;
        end
      end
      PEND: begin
        if (bus.frame_end) begin
          state_s = SWAP;
        end else begin
          state_s = PEND;
        end
      end
      SWAP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Swap state register; the displayed bank flips at the end of the frame_end cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      disp_bank_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      disp_bank_r <= disp_bank_r ^ ((state_r == PEND) && bus.frame_end);
    end
  end

  assign bus.rd_gnt    = rd_gnt_s;
  assign bus.wr_ack    = wr_win_s;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.disp_bank = disp_bank_r;
  assign bus.swap_pend = (state_r != IDLE);
  assign bus.swap_done = (state_r == SWAP);
  assign bus.busy      = busy_s;
endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Randomized bench for fb_bank_arbiter against a rule-level model with a shadow picture memory.
module tb_fb_bank_arbiter;
  localparam int AW = 11;
  localparam int DW = 12;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_bank_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Frame-buffer RAM with one cycle of read latency.
  logic [DW-1:0] ram [0:4095];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  int            starve;
  bit            waiting;
  bit            done_cycle;
  bit            bank;
  logic [AW:0]   last_addr;
  logic [DW-1:0] last_wdata;
  bit            exp_valid;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] ref_mem [0:4095];
  bit            obs_gnt;
  bit            obs_ack;
  logic [AW:0]   obs_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    starve     = 0;
    waiting    = 1'b0;
    done_cycle = 1'b0;
    bank       = 1'b0;
    last_addr  = '0;
    last_wdata = '0;
    exp_valid  = 1'b0;
    obs_gnt    = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.swap_req = 1'b0; bus.frame_end = 1'b0;
  endtask

  // Wait out the zero-fill sweep (only present when the clear feature is built in).
  task automatic wait_clear();
`ifdef FB_CLEAR_EN
    int n;
    n = 0;
    bus.rd_req = 1'b1;
    while (bus.busy && n < 5000) begin
      check_eq("clear_no_gnt", 32'(bus.rd_gnt), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check_eq("clear_len", 32'(n), 32'd4096);
    bus.rd_req = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      ref_mem[a] = '0;
      check_eq("clear_zero", 32'(ram[a]), 32'd0);
    end
    last_addr  = '1;
    last_wdata = '0;
`endif
  endtask

  // One clock: check grants against the model, advance the model, check registered outputs.
  task automatic cyc();
    bit            ew;
    bit            er;
    logic [AW:0]   ea;
    logic [DW-1:0] ed;
    #1;
    ew = bus.wr_req && (!bus.rd_req || starve == SM);
    er = bus.rd_req && !ew;
    ea = er ? {bank, bus.rd_addr} : (ew ? {~bank, bus.wr_addr} : last_addr);
    ed = ew ? bus.wr_data : last_wdata;
    check_eq("rd_gnt",    32'(bus.rd_gnt),    32'(er));
    check_eq("wr_ack",    32'(bus.wr_ack),    32'(ew));
    check_eq("mem_we",    32'(bus.mem_we),    32'(ew));
    check_eq("mem_addr",  32'(bus.mem_addr),  32'(ea));
    check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
    obs_gnt  = bus.rd_gnt;
    obs_ack  = bus.wr_ack;
    obs_addr = bus.mem_addr;
    @(posedge clk);
    if (er) exp_rdata = ref_mem[{bank, bus.rd_addr}];
    if (ew) ref_mem[{~bank, bus.wr_addr}] = bus.wr_data;
    exp_valid  = er;
    last_addr  = ea;
    last_wdata = ed;
    starve = (!bus.wr_req || ew) ? 0 : ((starve < SM) ? starve + 1 : SM);
    if (done_cycle) begin
      done_cycle = 1'b0;
    end else if (waiting) begin
      if (bus.frame_end) begin
        bank       = ~bank;
        waiting    = 1'b0;
        done_cycle = 1'b1;
      end
    end else if (bus.swap_req) begin
      waiting = 1'b1;
    end
    #1;
    check_eq("rd_valid",  32'(bus.rd_valid),  32'(exp_valid));
    if (exp_valid) check_eq("rd_data", 32'(bus.rd_data), 32'(exp_rdata));
    check_eq("disp_bank", 32'(bus.disp_bank), 32'(bank));
    check_eq("swap_pend", 32'(bus.swap_pend), 32'(waiting || done_cycle));
    check_eq("swap_done", 32'(bus.swap_done), 32'(done_cycle));
    check_eq("busy",      32'(bus.busy),      32'd0);
  endtask

  initial begin
    int pend_cnt;
    for (int a = 0; a < 4096; a++) begin
      ram[a]     = '0;
      ref_mem[a] = '0;
    end
    idle_inputs();
    model_reset();

    #12;
    check_eq("rst_disp_bank", 32'(bus.disp_bank), 32'd0);
    check_eq("rst_swap_pend", 32'(bus.swap_pend), 32'd0);
    check_eq("rst_swap_done", 32'(bus.swap_done), 32'd0);
    check_eq("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    check_eq("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check_eq("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b1;
`ifdef FB_CLEAR_EN
    wait_clear();
`else
    @(posedge clk); #1;
`endif

    // Single read, then single write to the back bank
    bus.rd_req = 1'b1; bus.rd_addr = 11'h005;
    cyc();
    check_eq("t1_addr", 32'(obs_addr), 32'h005);
    bus.rd_req = 1'b0;
    cyc();
    bus.wr_req = 1'b1; bus.wr_addr = 11'h010; bus.wr_data = 12'hF0A;
    cyc();
    check_eq("t2_addr", 32'(obs_addr), 32'h810);
    bus.wr_req = 1'b0;
    cyc();

    // Both requesters held: eight reads then one forced write, repeating
    bus.rd_req = 1'b1; bus.rd_addr = 11'h010;
    bus.wr_req = 1'b1; bus.wr_addr = 11'h021; bus.wr_data = 12'h5A5;
    for (int i = 0; i < 27; i++) begin
      cyc();
      check_eq("starve_ack", 32'(obs_ack), 32'((i % 9) == 8));
      check_eq("starve_gnt", 32'(obs_gnt), 32'((i % 9) != 8));
    end
    idle_inputs();
    cyc();

    // Swap request, frame_end 100 cycles later
    pend_cnt = 0;
    bus.swap_req = 1'b1;
    for (int i = 0; i < 103; i++) begin
      cyc();
      bus.swap_req  = 1'b0;
      bus.frame_end = (i == 99);
      pend_cnt += int'(bus.swap_pend);
      if (i == 100) check_eq("swap_bank_new", 32'(bus.disp_bank), 32'd1);
      if (i == 100) check_eq("swap_done_pulse", 32'(bus.swap_done), 32'd1);
    end
    check_eq("swap_pend_len", 32'(pend_cnt), 32'd101);
    bus.wr_req = 1'b1; bus.wr_addr = 11'h033; bus.wr_data = 12'h123;
    cyc();
    check_eq("post_swap_msb", 32'(obs_addr[AW]), 32'd0);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 11'h010;
    cyc();
    bus.rd_req = 1'b0;
    cyc();

    // swap_req together with frame_end: swap waits for the next frame_end
    bus.swap_req = 1'b1; bus.frame_end = 1'b1;
    cyc();
    bus.swap_req = 1'b0; bus.frame_end = 1'b0;
    check_eq("same_cyc_bank", 32'(bus.disp_bank), 32'd1);
    cyc(); cyc();
    check_eq("same_cyc_pend", 32'(bus.swap_pend), 32'd1);
    bus.frame_end = 1'b1;
    cyc();
    bus.frame_end = 1'b0;
    check_eq("same_cyc_swap", 32'(bus.disp_bank), 32'd0);
    cyc();

    // Randomized traffic with a reset in the middle of a read
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        idle_inputs();
        bus.rd_req = 1'b1; bus.rd_addr = 11'h007;
        cyc();
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.rd_valid),  32'd0);
        check_eq("mid_rst_bank",  32'(bus.disp_bank), 32'd0);
        check_eq("mid_rst_pend",  32'(bus.swap_pend), 32'd0);
        check_eq("mid_rst_gnt",   32'(bus.rd_gnt),    32'd0);
        idle_inputs();
        model_reset();
        #1;
        rst = 1'b1;
        wait_clear();
      end
      if (!bus.rd_req || obs_gnt) begin
        bus.rd_req  = ($urandom_range(0, 3) != 0);
        bus.rd_addr = AW'($urandom_range(0, 15));
      end
      if (!bus.wr_req || obs_ack) begin
        bus.wr_req  = ($urandom_range(0, 2) != 0);
        bus.wr_addr = AW'($urandom_range(0, 15));
        bus.wr_data = DW'($urandom);
      end
      bus.swap_req  = ($urandom_range(0, 29) == 0);
      bus.frame_end = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
